imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-port synchronous word SRAM between the core's instruction-fetch port and its load/store data port.
- Sits between the core and the unified memory, replacing the separate instruction and data memories used for riscv-tests runs.
- Grants at most one access per cycle. Data has priority, with an anti-starvation streak limit for fetch.
- Every accepted request gets exactly one response pulse one cycle later.

Parameters:
- ADDR_W, 12, SRAM word-index width. Memory covers 2^ADDR_W words; byte address bits [ADDR_W+1:2] are used.
- STREAK_MAX, 4, maximum consecutive data grants while a fetch is pending. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  fetch request.
- if_req_addr  in  32  fetch byte address.
- if_req_ready  out  1  fetch request granted this cycle.
- if_flush  in  1  kill fetch traffic this cycle (branch redirect).
- if_rsp_valid  out  1  fetch data valid.
- if_rsp_data  out  32  fetched word.
- d_req_valid  in  1  data request.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_addr  in  32  data byte address.
- d_req_wdata  in  32  store data, already lane-aligned.
- d_req_wstrb  in  4  store byte enables.
- d_req_ready  out  1  data request granted this cycle.
- d_rsp_valid  out  1  load data valid, or store acknowledge.
- d_rsp_data  out  32  loaded word; 0 for store acks.
- mem_en  out  1  SRAM access enable.
- mem_we  out  4  SRAM byte write enables.
- mem_addr  out  ADDR_W  SRAM word index.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data; valid the cycle after a read with mem_en=1 and mem_we=0.

Behaviour:
- Reset values: every output is 0; owner = NONE; streak = 0.
- Async reset mid-operation drops any in-flight response. No rsp_valid is produced after reset deasserts for requests granted before it.

Grant logic (combinational, cycle N):
- gi = if_req_valid & ~if_flush.
- gd = d_req_valid.
- Data is granted if gd & ~(gi & streak==STREAK_MAX).
- Fetch is granted if gi & not data-granted.
- if_req_ready and d_req_ready equal the respective grants. A ready is never high without its valid.
- A requester holds valid and address stable until ready.

Memory drive:
- Granted access drives mem_en=1 and mem_addr = addr[ADDR_W+1:2]. Addr[1:0] and upper bits are ignored (address wraps modulo 2^ADDR_W words).
- Store: mem_we = d_req_wstrb, mem_wdata = d_req_wdata. A store with wstrb=0000 is still granted and acknowledged, with no memory change.
- Load or fetch: mem_we = 0000.
- No grant: mem_en=0, mem_we=0000.

Streak counter (4 bits, registered):
- Data granted while if_req_valid & ~if_flush: increment.
- Fetch granted: clear.
- if_req_valid=0 or if_flush=1: clear.
- Never exceeds STREAK_MAX.

Owner state machine (registered at N+1):
- States: NONE, IF_RD, D_RD, D_WR.
- Next state: IF_RD if fetch granted, D_RD if data load granted, D_WR if data store granted, else NONE.
- Transitions occur every cycle. Back-to-back grants are allowed, giving a throughput of 1 access per cycle.

Responses (cycle N+1, no backpressure; the core always accepts):
- if_rsp_valid = (owner==IF_RD) & ~if_flush. if_rsp_data = mem_rdata when owner==IF_RD, else 0.
- if_flush therefore suppresses a fetch response arriving in the same cycle and blocks a fetch grant in that cycle.
- d_rsp_valid = owner==D_RD or owner==D_WR.
- d_rsp_data = mem_rdata for D_RD, 0 for D_WR.

Ordering and hazards:
- Requests are strictly serialised through the single port, so there is no read-during-write hazard.
- A load granted the cycle after a store to the same word returns the merged post-write word.

Test Plan:
- Fetch only: SRAM[4]=0x00500093; if_req_valid, addr 0x10 at N -> if_req_ready=1 at N; if_rsp_valid=1 and if_rsp_data=0x00500093 at N+1; mem_en=0 at N+1 when no new request.
- Store then load: SRAM[0x40]=0xAABBCCDD; store addr 0x100, wdata 0x11223344, wstrb 0011 at N; load addr 0x100 at N+1 -> d_rsp_valid at N+1 with d_rsp_data=0; d_rsp_data=0xAABB3344 at N+2.
- Contention with STREAK_MAX=4: both valid continuously for 12 cycles -> grant sequence D,D,D,D,I,D,D,D,D,I,D,D; each response lands on the correct port one cycle after its grant.
- Flush: fetch granted at N, if_flush=1 at N+1 with if_req_valid and d_req_valid both high -> if_rsp_valid=0 at N+1; d_req_ready=1 and if_req_ready=0 at N+1; streak stays 0.
- Reset mid-access: load granted at N, rst asserted between N and N+1 -> d_rsp_valid=0 and all outputs 0 during reset; no response after release.
- Address wrap: fetch addr 0x4010 (ADDR_W=12) -> mem_addr=0x004; addr 0x13 -> mem_addr=0x004.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and load/store.
// Data has priority; a streak counter forces a fetch grant after STREAK_MAX back-to-back data wins.
module imem_dmem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [31:0]       if_req_addr,
  output logic              if_req_ready,
  input  logic              if_flush,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [31:0]       d_req_addr,
  input  logic [31:0]       d_req_wdata,
  input  logic [3:0]        d_req_wstrb,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_data,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

  typedef enum logic [1:0] {NONE, IF_RD, D_RD, D_WR} owner_e;

  owner_e     owner_p1, owner_nxt;
  logic [3:0] streak_p1, streak_nxt;
  logic       gi_p0, gd_p0, gnt_d_p0, gnt_if_p0;

  // Ignored address bits: byte offset and everything above the word index.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_req_addr[31:ADDR_W+2], if_req_addr[1:0],
                              d_req_addr[31:ADDR_W+2], d_req_addr[1:0]};

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= STREAK_LIM) ? STREAK_LIM : v + 4'd1;
  endfunction

  // Stage p0: combinational grant and SRAM drive
  always_comb begin
    gi_p0     = if_req_valid & ~if_flush & ~rst;
    gd_p0     = d_req_valid & ~rst;
    gnt_d_p0  = gd_p0 & ~(gi_p0 & (streak_p1 == STREAK_LIM));
    gnt_if_p0 = gi_p0 & ~gnt_d_p0;
  end

  always_comb begin
    if_req_ready = gnt_if_p0;
    d_req_ready  = gnt_d_p0;
    mem_en       = gnt_d_p0 | gnt_if_p0;
    mem_we       = 4'b0000;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (gnt_d_p0) begin
      mem_addr = d_req_addr[ADDR_W+1:2];
      if (d_req_we) begin
        mem_we    = d_req_wstrb;
        mem_wdata = d_req_wdata;
      end
    end else if (gnt_if_p0) begin
      mem_addr = if_req_addr[ADDR_W+1:2];
    end
  end

  always_comb begin
    owner_nxt  = NONE;
    streak_nxt = streak_p1;
    if (gnt_if_p0)                 owner_nxt = IF_RD;
    else if (gnt_d_p0 && d_req_we) owner_nxt = D_WR;
    else if (gnt_d_p0)             owner_nxt = D_RD;

    if (!gi_p0 || gnt_if_p0) streak_nxt = 4'd0;
    else if (gnt_d_p0)       streak_nxt = sat_inc(streak_p1);
  end

  // Stage p1: owner of the access whose read data returns this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_p1  <= NONE;
      streak_p1 <= 4'd0;
    end else begin
      owner_p1  <= owner_nxt;
      streak_p1 <= streak_nxt;
    end
  end

  always_comb begin
    if_rsp_valid = (owner_p1 == IF_RD) & ~if_flush;
    if_rsp_data  = (owner_p1 == IF_RD) ? mem_rdata : 32'h0;
    d_rsp_valid  = (owner_p1 == D_RD) | (owner_p1 == D_WR);
    d_rsp_data   = (owner_p1 == D_RD) ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: vector table for single-cycle grant/drive behaviour
// plus hand-written sequences for fetch, store/load merge, contention, flush and reset.
module tb_imem_dmem_arbiter;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_valid;
  logic [31:0]       if_req_addr;
  logic              if_req_ready;
  logic              if_flush;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_data;
  logic              d_req_valid;
  logic              d_req_we;
  logic [31:0]       d_req_addr;
  logic [31:0]       d_req_wdata;
  logic [3:0]        d_req_wstrb;
  logic              d_req_ready;
  logic              d_rsp_valid;
  logic [31:0]       d_rsp_data;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.ADDR_W(ADDR_W), .STREAK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port SRAM model
  logic [31:0] sram [1<<ADDR_W];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      if (mem_we == 4'b0000) mem_rdata <= sram[mem_addr];
    end
  end

  typedef struct {
    logic        ifv;
    logic [31:0] ifa;
    logic        fl;
    logic        dv;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        e_ifr;
    logic        e_dr;
    logic        e_en;
    logic [3:0]  e_we;
    logic [11:0] e_addr;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_if(input logic v, input logic [31:0] a, input logic fl);
    if_req_valid = v;
    if_req_addr  = a;
    if_flush     = fl;
  endtask

  task automatic set_d(input logic v, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] s);
    d_req_valid = v;
    d_req_we    = we;
    d_req_addr  = a;
    d_req_wdata = wd;
    d_req_wstrb = s;
  endtask

  task automatic idle();
    set_if(1'b0, 32'h0, 1'b0);
    set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store_word(input logic [31:0] a, input logic [31:0] d);
    set_d(1'b1, 1'b1, a, d, 4'hF);
    #1 chk("preload_ready", {31'b0, d_req_ready}, 32'd1);
    cyc();
    idle();
    #1 chk("preload_ack", {31'b0, d_req_ready | d_rsp_valid}, 32'd1);
    cyc();
  endtask

  logic prev_if, prev_d, exp_d;

  initial begin
    //           ifv  ifa           fl  dv  we  da            wd            ws     ifr dr  en  we     addr    wdata
    vecs[0]  = '{1'b0, 32'h0,       0, 0, 0, 32'h0,       32'h0,       4'h0, 0, 0, 0, 4'h0, 12'h000, 32'h0};
    vecs[1]  = '{1'b1, 32'h10,      0, 0, 0, 32'h0,       32'h0,       4'h0, 1, 0, 1, 4'h0, 12'h004, 32'h0};
    vecs[2]  = '{1'b1, 32'h4010,    0, 0, 0, 32'h0,       32'h0,       4'h0, 1, 0, 1, 4'h0, 12'h004, 32'h0};
    vecs[3]  = '{1'b1, 32'h13,      0, 0, 0, 32'h0,       32'h0,       4'h0, 1, 0, 1, 4'h0, 12'h004, 32'h0};
    vecs[4]  = '{1'b0, 32'h0,       0, 1, 0, 32'h100,     32'h0,       4'h0, 0, 1, 1, 4'h0, 12'h040, 32'h0};
    vecs[5]  = '{1'b0, 32'h0,       0, 1, 1, 32'h200,     32'hCAFEF00D, 4'hA, 0, 1, 1, 4'hA, 12'h080, 32'hCAFEF00D};
    vecs[6]  = '{1'b0, 32'h0,       0, 1, 1, 32'h300,     32'h12345678, 4'h0, 0, 1, 1, 4'h0, 12'h0C0, 32'h12345678};
    vecs[7]  = '{1'b1, 32'h20,      0, 1, 0, 32'h104,     32'h0,       4'h0, 0, 1, 1, 4'h0, 12'h041, 32'h0};
    vecs[8]  = '{1'b1, 32'h20,      1, 0, 0, 32'h0,       32'h0,       4'h0, 0, 0, 0, 4'h0, 12'h000, 32'h0};
    vecs[9]  = '{1'b1, 32'h20,      1, 1, 0, 32'h108,     32'h0,       4'h0, 0, 1, 1, 4'h0, 12'h042, 32'h0};
    vecs[10] = '{1'b0, 32'h0,       0, 1, 1, 32'hFFFFFFFC, 32'h0000BEEF, 4'hF, 0, 1, 1, 4'hF, 12'hFFF, 32'h0000BEEF};

    // Reset: requests present but nothing may be granted or driven
    rst = 1'b1;
    set_if(1'b1, 32'h10, 1'b0);
    set_d(1'b1, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF);
    #2;
    chk("rst_if_ready", {31'b0, if_req_ready}, 32'd0);
    chk("rst_d_ready",  {31'b0, d_req_ready},  32'd0);
    chk("rst_mem_en",   {31'b0, mem_en},       32'd0);
    chk("rst_mem_we",   {28'b0, mem_we},       32'd0);
    chk("rst_rsp",      {30'b0, if_rsp_valid, d_rsp_valid}, 32'd0);
    cyc();
    cyc();
    idle();
    rst = 1'b0;
    cyc();

    store_word(32'h10, 32'h00500093);
    store_word(32'h100, 32'hAABBCCDD);

    // Fetch only
    set_if(1'b1, 32'h10, 1'b0);
    #1 chk("fetch_ready", {31'b0, if_req_ready}, 32'd1);
    chk("fetch_addr", {20'b0, mem_addr}, 32'h004);
    cyc();
    idle();
    #1 chk("fetch_rsp_valid", {31'b0, if_rsp_valid}, 32'd1);
    chk("fetch_rsp_data", if_rsp_data, 32'h00500093);
    chk("fetch_idle_en", {31'b0, mem_en}, 32'd0);
    cyc();

    // Store partial word then load it back next cycle
    set_d(1'b1, 1'b1, 32'h100, 32'h11223344, 4'b0011);
    #1 chk("st_ready", {31'b0, d_req_ready}, 32'd1);
    cyc();
    set_d(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    #1 chk("st_ack_valid", {31'b0, d_rsp_valid}, 32'd1);
    chk("st_ack_data", d_rsp_data, 32'h0);
    chk("ld_ready", {31'b0, d_req_ready}, 32'd1);
    cyc();
    idle();
    #1 chk("ld_rsp_valid", {31'b0, d_rsp_valid}, 32'd1);
    chk("ld_rsp_data", d_rsp_data, 32'hAABB3344);
    cyc();

    // Contention: D,D,D,D,I,D,D,D,D,I,D,D
    prev_if = 1'b0;
    prev_d  = 1'b0;
    for (int k = 0; k < 12; k++) begin
      set_if(1'b1, 32'h10, 1'b0);
      set_d(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
      exp_d = !(k == 4 || k == 9);
      #1;
      chk($sformatf("cont%0d_d_ready", k),  {31'b0, d_req_ready},  {31'b0, exp_d});
      chk($sformatf("cont%0d_if_ready", k), {31'b0, if_req_ready}, {31'b0, ~exp_d});
      if (k > 0) begin
        chk($sformatf("cont%0d_if_rsp", k), {31'b0, if_rsp_valid}, {31'b0, prev_if});
        chk($sformatf("cont%0d_d_rsp", k),  {31'b0, d_rsp_valid},  {31'b0, prev_d});
        chk($sformatf("cont%0d_data", k), prev_if ? if_rsp_data : d_rsp_data,
            prev_if ? 32'h00500093 : 32'hAABB3344);
      end
      prev_if = ~exp_d;
      prev_d  = exp_d;
      cyc();
    end
    idle();
    #1 chk("cont_last_d_rsp", {31'b0, d_rsp_valid}, 32'd1);
    chk("cont_last_if_rsp", {31'b0, if_rsp_valid}, 32'd0);
    cyc();

    // Flush kills the in-flight fetch response and blocks the fetch grant
    set_if(1'b1, 32'h10, 1'b0);
    #1 chk("fl_fetch_ready", {31'b0, if_req_ready}, 32'd1);
    cyc();
    set_if(1'b1, 32'h10, 1'b1);
    set_d(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    #1 chk("fl_if_rsp", {31'b0, if_rsp_valid}, 32'd0);
    chk("fl_d_ready",  {31'b0, d_req_ready},  32'd1);
    chk("fl_if_ready", {31'b0, if_req_ready}, 32'd0);
    cyc();
    for (int j = 0; j < 5; j++) begin
      set_if(1'b1, 32'h10, 1'b0);
      #1 chk($sformatf("fl_streak%0d_d", j),  {31'b0, d_req_ready},  {31'b0, j < 4});
      chk($sformatf("fl_streak%0d_if", j), {31'b0, if_req_ready}, {31'b0, j == 4});
      cyc();
    end
    idle();
    cyc();

    // Reset mid-access drops the pending load response
    set_if(1'b1, 32'h10, 1'b0);
    set_d(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    #1 chk("mr_d_ready", {31'b0, d_req_ready}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mr_rsp",   {30'b0, if_rsp_valid, d_rsp_valid}, 32'd0);
    chk("mr_ready", {30'b0, if_req_ready, d_req_ready}, 32'd0);
    chk("mr_mem",   {15'b0, mem_en, mem_we, mem_addr}, 32'd0);
    cyc();
    chk("mr_rsp_after_edge", {30'b0, if_rsp_valid, d_rsp_valid}, 32'd0);
    chk("mr_data", d_rsp_data | if_rsp_data | mem_wdata, 32'd0);
    idle();
    #1 rst = 1'b0;
    #1 chk("mr_rel_rsp", {31'b0, d_rsp_valid}, 32'd0);
    cyc();
    chk("mr_rel_rsp2", {30'b0, if_rsp_valid, d_rsp_valid}, 32'd0);
    cyc();

    // Single-cycle vector table
    for (int i = 0; i < 11; i++) begin
      set_if(vecs[i].ifv, vecs[i].ifa, vecs[i].fl);
      set_d(vecs[i].dv, vecs[i].dwe, vecs[i].da, vecs[i].wd, vecs[i].ws);
      #1;
      chk($sformatf("v%0d_if_ready", i), {31'b0, if_req_ready}, {31'b0, vecs[i].e_ifr});
      chk($sformatf("v%0d_d_ready", i),  {31'b0, d_req_ready},  {31'b0, vecs[i].e_dr});
      chk($sformatf("v%0d_mem_en", i),   {31'b0, mem_en},       {31'b0, vecs[i].e_en});
      chk($sformatf("v%0d_mem_we", i),   {28'b0, mem_we},       {28'b0, vecs[i].e_we});
      chk($sformatf("v%0d_mem_addr", i), {20'b0, mem_addr},     {20'b0, vecs[i].e_addr});
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata,            vecs[i].e_wd);
      cyc();
      idle();
      #1;
      chk($sformatf("v%0d_if_rsp", i), {31'b0, if_rsp_valid}, {31'b0, vecs[i].e_ifr});
      chk($sformatf("v%0d_d_rsp", i),  {31'b0, d_rsp_valid},  {31'b0, vecs[i].e_dr});
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
